// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, fixed wait states,
// RV32I byte/half/word access on an internal word array, registered response.
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_op,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    // state | meaning
    // IDLE  | ready for a request
    // WAIT  | counting wait states; access happens when the counter reaches 0
    // RESP  | response held until resp_ready
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;

    logic [1:0]            state;
    logic [3:0]            cnt;
    logic                  wrReg;
    logic [ADDR_WIDTH+1:0] addrReg;
    logic [31:0]           wdataReg;
    logic [2:0]            opReg;

    logic [31:0]           mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] wordIdx;
    logic [31:0]           curWord;
    logic [7:0]            byteSel;
    logic [15:0]           halfSel;
    logic                  accessErr;
    logic [31:0]           loadData;
    logic [31:0]           storeWord;
    logic                  doAccess;
    logic                  unusedAddrHi;

    assign unusedAddrHi = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready = rst && (state == IDLE);
    assign wordIdx   = addrReg[ADDR_WIDTH+1:2];
    assign curWord   = mem[wordIdx];
    assign byteSel   = 8'(curWord >> {addrReg[1:0], 3'b000});
    assign halfSel   = addrReg[1] ? curWord[31:16] : curWord[15:0];
    assign doAccess  = (state == WAIT) && (cnt == 4'd0);

    always_comb begin
        accessErr = 1'b0;
        case (opReg)
            3'b000:  accessErr = 1'b0;
            3'b001:  accessErr = addrReg[0];
            3'b010:  accessErr = (addrReg[1:0] != 2'b00);
            3'b100:  accessErr = wrReg;
            3'b101:  accessErr = wrReg || addrReg[0];
            default: accessErr = 1'b1;
        endcase
    end

    always_comb begin
        loadData = 32'd0;
        case (opReg)
            3'b000:  loadData = {{24{byteSel[7]}}, byteSel};
            3'b001:  loadData = {{16{halfSel[15]}}, halfSel};
            3'b010:  loadData = curWord;
            3'b100:  loadData = {24'd0, byteSel};
            3'b101:  loadData = {16'd0, halfSel};
            default: loadData = 32'd0;
        endcase
    end

    // Read-modify-write: only the addressed lanes take new data.
    always_comb begin
        storeWord = curWord;
        case (opReg)
            3'b000:  storeWord[{addrReg[1:0], 3'b000} +: 8] = wdataReg[7:0];
            3'b001:  storeWord[{addrReg[1], 4'b0000} +: 16] = wdataReg[15:0];
            3'b010:  storeWord = wdataReg;
            default: storeWord = curWord;
        endcase
    end

    // Array is intentionally not reset; reset drops state so a pending store never fires.
    always_ff @(posedge clk) begin
        if (doAccess && wrReg && !accessErr) begin
            mem[wordIdx] <= storeWord;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            wrReg      <= 1'b0;
            addrReg    <= '0;
            wdataReg   <= 32'd0;
            opReg      <= 3'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wrReg    <= req_write;
                        addrReg  <= req_addr[ADDR_WIDTH+1:0];
                        wdataReg <= req_wdata;
                        opReg    <= req_op;
                        cnt      <= WAIT_INIT;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= (wrReg || accessErr) ? 32'd0 : loadData;
                        resp_err   <= accessErr;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
